// File: rtl/lidar_feat_pkg.sv
// Shared widths, vector type and serializer state encoding for the LiDAR
// feature path.
package lidar_feat_pkg;

    localparam int unsigned FEAT_W     = 32;
    localparam int unsigned FEAT_WORDS = 8;
    localparam int unsigned VEC_W      = FEAT_W * FEAT_WORDS;

    typedef logic [VEC_W-1:0] feat_vec_t;

    typedef enum logic {
        IDLE,
        STREAM
    } ser_state_t;

    // Word 0 (cx) occupies the most significant 32 bits.
    function automatic logic [FEAT_W-1:0] feat_word(input feat_vec_t vec, input logic [2:0] idx);
        return vec[(FEAT_WORDS - 1 - int'(idx)) * FEAT_W +: FEAT_W];
    endfunction

endpackage

// File: rtl/feat_vector_fifo.sv
// Synchronous DEPTH x 256-bit FIFO with a registered occupancy count.
// A write while full is accepted only when a read happens in the same cycle.
module feat_vector_fifo
    import lidar_feat_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  feat_vec_t              wr_data,
    input  logic                   rd_en,
    output feat_vec_t              rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    feat_vec_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/feature_vector_serializer.sv
// Buffers 256-bit feature vectors and streams each as eight 32-bit words
// over valid/ready; vectors arriving while the FIFO is full are dropped and counted.
module feature_vector_serializer
    import lidar_feat_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   vector_valid,
    input  logic [VEC_W-1:0]       feature_vector,
    output logic [FEAT_W-1:0]      m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [2:0]             m_tuser,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   drop_pulse,
    output logic [CNT_W-1:0]       drop_count
);

    ser_state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    feat_vec_t  hold_q, hold_d;
    feat_vec_t  fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       drop;

    feat_vector_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_en  (vector_valid),
        .wr_data(feature_vector),
        .rd_en  (pop),
        .rd_data(fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // The final beat and the next pop share a cycle so back-to-back vectors have no bubble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = fifo_head;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (m_tready) begin
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                    end else if (!fifo_empty) begin
                        pop    = 1'b1;
                        hold_d = fifo_head;
                        idx_d  = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign drop = vector_valid && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            drop_pulse <= drop;
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign m_tvalid = (state_q == STREAM);
    assign m_tdata  = feat_word(hold_q, idx_q);
    assign m_tuser  = idx_q;
    assign m_tlast  = m_tvalid && (idx_q == 3'd7);

endmodule

// File: tb/tb_feature_vector_serializer.sv
// Directed and random stimulus for feature_vector_serializer, checked every
// cycle against a queue-based transaction model; a 3-bit-counter instance covers saturation.
module tb_feature_vector_serializer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         vector_valid = 1'b0;
    logic [255:0] feature_vector = '0;
    logic         m_tready = 1'b0;

    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic [2:0]   m_tuser;
    logic [2:0]   fifo_level;
    logic         drop_pulse;
    logic [15:0]  drop_count;

    logic [31:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic [2:0]   s_tuser;
    logic [2:0]   s_fifo_level;
    logic         s_drop_pulse;
    logic [2:0]   s_drop_count;

    feature_vector_serializer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .vector_valid(vector_valid), .feature_vector(feature_vector),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .fifo_level(fifo_level), .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    feature_vector_serializer #(.DEPTH(DEPTH), .CNT_W(3)) dut_sat (
        .clk(clk), .reset_n(reset_n), .vector_valid(vector_valid), .feature_vector(feature_vector),
        .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(m_tready), .m_tlast(s_tlast),
        .m_tuser(s_tuser), .fifo_level(s_fifo_level), .drop_pulse(s_drop_pulse), .drop_count(s_drop_count)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction model: pending vectors, the vector on the wire and its beat number.
    logic [255:0] q[$];
    bit           busy;
    int           beat;
    logic [255:0] cur;
    int           drops;
    bit           exp_pulse;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        busy      = 1'b0;
        beat      = 0;
        cur       = '0;
        drops     = 0;
        exp_pulse = 1'b0;
    endtask

    task automatic model_update(input bit vv, input logic [255:0] vec, input bit rdy);
        bit hs, pop, accept;
        hs     = busy && rdy;
        pop    = (q.size() > 0) && (!busy || (hs && beat == 7));
        accept = vv && ((q.size() < DEPTH) || pop);
        exp_pulse = vv && !accept;
        if (exp_pulse && drops < 65535) drops++;
        if (hs) begin
            if (beat == 7) begin
                busy = 1'b0;
                beat = 0;
            end else begin
                beat++;
            end
        end
        if (pop) begin
            cur  = q.pop_front();
            busy = 1'b1;
            beat = 0;
        end
        if (accept) q.push_back(vec);
    endtask

    task automatic check_all();
        logic [31:0] word;
        word = cur[255 - 32*beat -: 32];
        chk("m_tvalid", m_tvalid, busy);
        if (busy) chk("m_tdata", m_tdata, word);
        chk("m_tuser", m_tuser, beat);
        chk("m_tlast", m_tlast, busy && beat == 7);
        chk("fifo_level", fifo_level, q.size());
        chk("drop_pulse", drop_pulse, exp_pulse);
        chk("drop_count", drop_count, drops);
        chk("sat_drop_pulse", s_drop_pulse, exp_pulse);
        chk("sat_drop_count", s_drop_count, (drops > 7) ? 7 : drops);
    endtask

    task automatic check_reset_outputs();
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tuser", m_tuser, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_drop_pulse", drop_pulse, 0);
        chk("rst_drop_count", drop_count, 0);
    endtask

    task automatic step(input bit vv, input logic [255:0] vec, input bit rdy);
        vector_valid   = vv;
        feature_vector = vec;
        m_tready       = rdy;
        @(posedge clk);
        if (reset_n) model_update(vv, vec, rdy);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
    endtask

    function automatic logic [255:0] mkvec(input int unsigned base);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[255 - 32*i -: 32] = base + i + 1;
        return v;
    endfunction

    function automatic logic [255:0] rndvec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        model_reset();
        #10;
        check_reset_outputs();
        reset_n = 1'b1;

        // Single vector, words 1..8, ready held high.
        step(1'b1, mkvec(0), 1'b1);
        chk("latency_k_tvalid", m_tvalid, 0);
        step(1'b0, '0, 1'b1);
        chk("latency_k1_tvalid", m_tvalid, 1);
        chk("first_word", m_tdata, 32'd1);
        idle(10, 1'b1);

        // Backpressure on word 3 for five cycles.
        step(1'b1, rndvec(), 1'b1);
        idle(4, 1'b1);
        chk("stall_tuser", m_tuser, 3);
        idle(5, 1'b0);
        chk("stall_hold_tuser", m_tuser, 3);
        idle(10, 1'b1);

        // Seven vectors with ready low: FIFO fills, two drops.
        for (int i = 0; i < 7; i++) step(1'b1, mkvec(32'h100 * (i + 1)), 1'b0);
        chk("fill_level", fifo_level, 4);
        chk("fill_drop_count", drop_count, 2);
        idle(48, 1'b1);

        // Two vectors back to back stream without a gap.
        step(1'b1, rndvec(), 1'b1);
        step(1'b1, rndvec(), 1'b1);
        idle(20, 1'b1);

        // Asynchronous reset during word 4.
        step(1'b1, rndvec(), 1'b1);
        idle(5, 1'b1);
        chk("pre_reset_tuser", m_tuser, 4);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        idle(3, 1'b1);
        reset_n = 1'b1;
        step(1'b1, mkvec(32'h5000), 1'b1);
        idle(12, 1'b1);

        // Flood with ready low: 9 drops saturate the 3-bit counter.
        for (int i = 0; i < 14; i++) step(1'b1, rndvec(), 1'b0);
        chk("flood_drop_count", drop_count, 9);
        chk("flood_sat_count", s_drop_count, 7);
        idle(48, 1'b1);

        // Random traffic and backpressure.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 4) == 0), rndvec(), ($urandom_range(0, 3) != 0));
        end
        idle(60, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
